clock_display_mux_n: RTL

// - Next-generation HH:MM[:SS] timekeeper with N-digit multiplexed 7-seg output. Sits between the debounced button/switch inputs and the board display pins.
// - Adds over the current clock: async active-low reset, 4- or 6-digit display, 12/24 h mode with PM flag and leading-zero blanking, hold-to-repeat on set buttons, parametrised polarity.

---
 rtl/clock_display_mux_n_pkg.sv | 58 +++++
 rtl/clock_display_mux_n_btn_repeat.sv | 66 ++++++
 rtl/clock_display_mux_n.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/clock_display_mux_n_pkg.sv
// Shared constants and helpers for the multiplexed clock display: time limits,
// 7-segment code table ({g..a}, 1 = lit) and a compare/subtract BCD split.
package clock_display_mux_n_pkg;

  localparam logic [5:0] SEC_MAX   = 6'd59;
  localparam logic [5:0] MIN_MAX   = 6'd59;
  localparam logic [4:0] HR_MAX    = 5'd23;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  // Values never exceed 59, so a short compare cascade replaces a divider.
  function automatic bcd_t to_bcd(input logic [5:0] v);
    bcd_t b;
    if (v >= 6'd50) begin
      b.tens = 4'd5;
      b.ones = 4'(v - 6'd50);
    end else if (v >= 6'd40) begin
      b.tens = 4'd4;
      b.ones = 4'(v - 6'd40);
    end else if (v >= 6'd30) begin
      b.tens = 4'd3;
      b.ones = 4'(v - 6'd30);
    end else if (v >= 6'd20) begin
      b.tens = 4'd2;
      b.ones = 4'(v - 6'd20);
    end else if (v >= 6'd10) begin
      b.tens = 4'd1;
      b.ones = 4'(v - 6'd10);
    end else begin
      b.tens = 4'd0;
      b.ones = v[3:0];
    end
    return b;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'h3F;
      4'd1:    c = 7'h06;
      4'd2:    c = 7'h5B;
      4'd3:    c = 7'h4F;
      4'd4:    c = 7'h66;
      4'd5:    c = 7'h6D;
      4'd6:    c = 7'h7D;
      4'd7:    c = 7'h07;
      4'd8:    c = 7'h7F;
      4'd9:    c = 7'h6F;
      default: c = SEG_BLANK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/clock_display_mux_n_btn_repeat.sv
// Set-button stepper: one step on a rising edge, then after DLY_CYC of holding,
// one step every PER_CYC until release.
module clock_display_mux_n_btn_repeat #(
  parameter int DLY_CYC = 25_000_000,
  parameter int PER_CYC = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic step_o
);

  localparam int CNT_MAX = (DLY_CYC > PER_CYC) ? DLY_CYC : PER_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DLY_VAL = CNT_W'(DLY_CYC);
  localparam logic [CNT_W-1:0] PER_VAL = CNT_W'(PER_CYC);

  logic             prev_q, prev_d;
  logic             armed_q, armed_d;
  logic             rep_q, rep_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  // prev resets high and armed low so a button held through reset stays inert.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
      rep_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
      rep_q   <= rep_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    prev_d  = btn_i;
    armed_d = armed_q;
    rep_d   = rep_q;
    cnt_d   = cnt_q;
    step_o  = 1'b0;
    rise    = btn_i & ~prev_q;
    if (!btn_i) begin
      armed_d = 1'b0;
      rep_d   = 1'b0;
      cnt_d   = '0;
    end else if (rise) begin
      step_o  = 1'b1;
      armed_d = 1'b1;
      rep_d   = 1'b0;
      cnt_d   = CNT_W'(1);
    end else if (armed_q) begin
      if ((!rep_q && cnt_q == DLY_VAL) || (rep_q && cnt_q == PER_VAL)) begin
        step_o = 1'b1;
        rep_d  = 1'b1;
        cnt_d  = CNT_W'(1);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_display_mux_n.sv
// HH:MM[:SS] timekeeper with set buttons, 12/24 h display and an N-digit
// multiplexed 7-segment driver with configurable output polarity.
module clock_display_mux_n
  import clock_display_mux_n_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int FAST_DIV       = 60,
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 200_000,
  parameter int REPEAT_DLY_CYC = 25_000_000,
  parameter int REPEAT_PER_CYC = 5_000_000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  speed_up,
  input  logic                  mode_12h,
  input  logic                  hour_inc,
  input  logic                  hour_dec,
  input  logic                  min_inc,
  input  logic                  min_dec,
  input  logic                  clear,
  input  logic [5:0]            sec_load,
  output logic [6:0]            segments,
  output logic [NUM_DIGITS-1:0] anodes,
  output logic [5:0]            leds,
  output logic                  pm
);

  localparam int DIV_W = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [DIV_W-1:0] LIM_NORM = DIV_W'(CLK_FREQ_HZ - 1);
  localparam logic [DIV_W-1:0] LIM_FAST = DIV_W'(CLK_FREQ_HZ / FAST_DIV - 1);
  localparam int REF_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{SEG_ACTIVE_LOW != 0}};
  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW != 0}};

  logic [1:0]            rst_sync_q, rst_sync_d;
  logic                  rst_int_n;
  logic [DIV_W-1:0]      div_q, div_d, div_lim;
  logic                  spd_q, spd_d;
  logic                  tick;
  logic [4:0]            h_q, h_d;
  logic [5:0]            m_q, m_d, s_q, s_d;
  logic [REF_W-1:0]      ref_q, ref_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic [5:0]            leds_q, leds_d;
  logic                  pm_q, pm_d;
  logic                  hr_up, hr_dn, mn_up, mn_dn;

  // Assertion is immediate; release is aligned to clk by two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_int_n = rst_sync_q[1];

  clock_display_mux_n_btn_repeat #(.DLY_CYC(REPEAT_DLY_CYC), .PER_CYC(REPEAT_PER_CYC))
    u_hr_inc (.clk(clk), .rst_n(rst_int_n), .btn_i(hour_inc), .step_o(hr_up));
  clock_display_mux_n_btn_repeat #(.DLY_CYC(REPEAT_DLY_CYC), .PER_CYC(REPEAT_PER_CYC))
    u_hr_dec (.clk(clk), .rst_n(rst_int_n), .btn_i(hour_dec), .step_o(hr_dn));
  clock_display_mux_n_btn_repeat #(.DLY_CYC(REPEAT_DLY_CYC), .PER_CYC(REPEAT_PER_CYC))
    u_mn_inc (.clk(clk), .rst_n(rst_int_n), .btn_i(min_inc), .step_o(mn_up));
  clock_display_mux_n_btn_repeat #(.DLY_CYC(REPEAT_DLY_CYC), .PER_CYC(REPEAT_PER_CYC))
    u_mn_dec (.clk(clk), .rst_n(rst_int_n), .btn_i(min_dec), .step_o(mn_dn));

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      div_q  <= '0;
      spd_q  <= 1'b0;
      h_q    <= '0;
      m_q    <= '0;
      s_q    <= '0;
      ref_q  <= '0;
      idx_q  <= '0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
      leds_q <= '0;
      pm_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      spd_q  <= spd_d;
      h_q    <= h_d;
      m_q    <= m_d;
      s_q    <= s_d;
      ref_q  <= ref_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      leds_q <= leds_d;
      pm_q   <= pm_d;
    end
  end

  // A speed_up change restarts the second so the new period starts clean.
  always_comb begin
    spd_d   = speed_up;
    div_lim = speed_up ? LIM_FAST : LIM_NORM;
    tick    = 1'b0;
    if (!run || (speed_up != spd_q)) begin
      div_d = '0;
    end else if (div_q == div_lim) begin
      div_d = '0;
      tick  = 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_comb begin
    h_d = h_q;
    m_d = m_q;
    s_d = s_q;
    if (clear) begin
      h_d = '0;
      m_d = '0;
      s_d = '0;
    end else if (run) begin
      if (tick) begin
        if (s_q == SEC_MAX) begin
          s_d = '0;
          if (m_q == MIN_MAX) begin
            m_d = '0;
            h_d = (h_q == HR_MAX) ? 5'd0 : h_q + 5'd1;
          end else begin
            m_d = m_q + 6'd1;
          end
        end else begin
          s_d = s_q + 6'd1;
        end
      end
    end else begin
      s_d = (sec_load > SEC_MAX) ? SEC_MAX : sec_load;
      // Opposing steps on one field cancel; hour and minute are independent.
      if (hr_up && !hr_dn) h_d = (h_q == HR_MAX) ? 5'd0 : h_q + 5'd1;
      if (hr_dn && !hr_up) h_d = (h_q == 5'd0) ? HR_MAX : h_q - 5'd1;
      if (mn_up && !mn_dn) m_d = (m_q == MIN_MAX) ? 6'd0 : m_q + 6'd1;
      if (mn_dn && !mn_up) m_d = (m_q == 6'd0) ? MIN_MAX : m_q - 6'd1;
    end
  end

  logic [4:0]            h_mod, disp_h;
  bcd_t                  bcd_h, bcd_m, bcd_s;
  logic                  blank_h10;
  logic [2:0]            sel;
  logic [6:0]            code;
  logic [NUM_DIGITS-1:0] an_hot;

  always_comb begin
    h_mod     = (h_q >= 5'd12) ? h_q - 5'd12 : h_q;
    disp_h    = mode_12h ? ((h_mod == 5'd0) ? 5'd12 : h_mod) : h_q;
    bcd_h     = to_bcd({1'b0, disp_h});
    bcd_m     = to_bcd(m_q);
    bcd_s     = to_bcd(s_q);
    blank_h10 = mode_12h && (bcd_h.tens == 4'd0);

    ref_d = ref_q + 1'b1;
    idx_d = idx_q;
    if (ref_q == REF_LAST) begin
      ref_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Digit slot 0 is seconds-ones; a 4-digit build starts at minutes-ones.
    sel = 3'(idx_q) + ((NUM_DIGITS == 4) ? 3'd2 : 3'd0);
    case (sel)
      3'd0:    code = seg_decode(bcd_s.ones);
      3'd1:    code = seg_decode(bcd_s.tens);
      3'd2:    code = seg_decode(bcd_m.ones);
      3'd3:    code = seg_decode(bcd_m.tens);
      3'd4:    code = seg_decode(bcd_h.ones);
      3'd5:    code = blank_h10 ? SEG_BLANK : seg_decode(bcd_h.tens);
      default: code = SEG_BLANK;
    endcase

    an_hot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
    an_d   = an_hot ^ AN_OFF;
    seg_d  = code ^ SEG_OFF;
    leds_d = s_q;
    pm_d   = mode_12h && (h_q >= 5'd12);
  end

  assign segments = seg_q;
  assign anodes   = an_q;
  assign leds     = leds_q;
  assign pm       = pm_q;

endmodule
